bitram_word_reader: RTL and testbench

//  Read-side client for a 512x1 asynchronous-read select RAM.

---
 rtl/bitram_word_reader.sv | 186 ++++++++++++++++++
 tb/tb_bitram_word_reader.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitram_word_reader.sv
// bitram_word_reader
// Read-side client for a 512x1 asynchronous-read bit RAM. A command gives
// a start bit address and a word count; the block walks the RAM address
// one bit per cycle, packs DATA_W bits per word and streams the words out
// on a valid/ready port, flagging the final word of the command with LAST.
//
// Ports
//   CLK, RST          clock; synchronous active-high reset
//   CMD_VALID/READY   command handshake (READY only in IDLE)
//   CMD_ADDR[8:0]     start bit address
//   CMD_WORDS[7:0]    number of words (0 = no-op)
//   RAM_A[8:0]        registered RAM address
//   RAM_O             asynchronous RAM read data for RAM_A
//   DOUT_VALID/READY  output word handshake
//   DOUT_DATA         packed word
//   DOUT_LAST         final word of the command
//   BUSY              state != IDLE or an output word is pending
//   DBG_STATE[1:0]    FSM state: 0 IDLE, 1 FETCH, 2 HOLD
//
// Handshakes: a transfer happens on a rising edge where VALID and READY are
// both high. While VALID=1 and READY=0 the producer holds DATA/LAST stable
// and keeps VALID high; VALID never depends combinationally on READY.
module bitram_word_reader #(
    parameter int   DATA_W    = 8,
    parameter logic MSB_FIRST = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [8:0]        CMD_ADDR,
    input  logic [7:0]        CMD_WORDS,
    output logic [8:0]        RAM_A,
    input  logic              RAM_O,
    output logic              DOUT_VALID,
    input  logic              DOUT_READY,
    output logic [DATA_W-1:0] DOUT_DATA,
    output logic              DOUT_LAST,
    output logic              BUSY,
    output logic [1:0]        DBG_STATE
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [8:0]          ram_a_q, ram_a_d;
    logic [7:0]          words_left_q, words_left_d;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   dout_data_q, dout_data_d;
    logic                dout_valid_q, dout_valid_d;
    logic                dout_last_q, dout_last_d;

    logic                cmd_accept;
    logic                out_free;
    logic                word_done;
    logic                load;
    logic                last_word;
    logic [DATA_W-1:0]   word_full;
    logic [DATA_W-1:0]   load_word;

    assign cmd_accept = (state_q == ST_IDLE) && CMD_VALID;
    // Output register can take a new word if empty or being drained this edge.
    assign out_free   = !dout_valid_q || DOUT_READY;
    assign word_done  = (state_q == ST_FETCH) && (bitcnt_q == LAST_BIT);
    assign last_word  = (words_left_q == 8'd1);
    assign load       = (word_done && out_free) || ((state_q == ST_HOLD) && out_free);

    // Word including the bit sampled this cycle. LSB-first shifts in at the
    // top so the first bit ends up at bit 0 after DATA_W shifts; MSB-first
    // shifts in at the bottom so the first bit ends up at the top.
    assign word_full = MSB_FIRST ? {shift_q[DATA_W-2:0], RAM_O}
                                 : {RAM_O, shift_q[DATA_W-1:1]};
    assign load_word = (state_q == ST_HOLD) ? shift_q : word_full;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_accept && (CMD_WORDS != 8'd0)) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (word_done) begin
                    if (out_free) begin
                        state_d = last_word ? ST_IDLE : ST_FETCH;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_free) begin
                    state_d = last_word ? ST_IDLE : ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        CMD_READY = (state_q == ST_IDLE);
        BUSY      = (state_q != ST_IDLE) || dout_valid_q;
        DBG_STATE = state_q;
    end

    // Datapath next-state
    always_comb begin
        ram_a_d      = ram_a_q;
        words_left_d = words_left_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        dout_data_d  = dout_data_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;

        if (cmd_accept) begin
            ram_a_d      = CMD_ADDR;
            words_left_d = CMD_WORDS;
            bitcnt_d     = '0;
        end

        if (state_q == ST_FETCH) begin
            shift_d  = word_full;
            ram_a_d  = ram_a_q + 9'd1;   // natural 9-bit wrap 511 -> 0
            bitcnt_d = word_done ? '0 : bitcnt_q + CNT_W'(1);
        end

        if (dout_valid_q && DOUT_READY) begin
            dout_valid_d = 1'b0;
        end

        // A load on the same edge as a transfer keeps VALID high: no bubble.
        if (load) begin
            dout_data_d  = load_word;
            dout_valid_d = 1'b1;
            dout_last_d  = last_word;
            words_left_d = words_left_q - 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ram_a_q      <= '0;
            words_left_q <= '0;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            dout_data_q  <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            ram_a_q      <= ram_a_d;
            words_left_q <= words_left_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            dout_data_q  <= dout_data_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
        end
    end

    assign RAM_A      = ram_a_q;
    assign DOUT_DATA  = dout_data_q;
    assign DOUT_VALID = dout_valid_q;
    assign DOUT_LAST  = dout_last_q;

endmodule

// File: tb/tb_bitram_word_reader.sv
// Bench for bitram_word_reader: an 8-bit LSB-first instance exercised with
// directed and randomized commands, plus a 4-bit MSB-first instance.
module tb_bitram_word_reader;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- shared bit RAM ----------------
    logic [511:0] ram_bits;

    // ---------------- 8-bit LSB-first DUT ----------------
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [8:0] cmd_addr = '0;
    logic [7:0] cmd_words = '0;
    logic [8:0] ram_a;
    logic       ram_o;
    logic       dout_valid;
    logic       dout_ready = 1'b1;
    logic [7:0] dout_data;
    logic       dout_last;
    logic       busy;
    logic [1:0] dbg_state;

    assign ram_o = ram_bits[ram_a];

    bitram_word_reader #(.DATA_W(8), .MSB_FIRST(1'b0)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_ADDR(cmd_addr), .CMD_WORDS(cmd_words),
        .RAM_A(ram_a), .RAM_O(ram_o),
        .DOUT_VALID(dout_valid), .DOUT_READY(dout_ready),
        .DOUT_DATA(dout_data), .DOUT_LAST(dout_last),
        .BUSY(busy), .DBG_STATE(dbg_state)
    );

    // ---------------- 4-bit MSB-first DUT ----------------
    logic       c4_valid = 1'b0;
    logic       c4_ready;
    logic [8:0] c4_addr = '0;
    logic [7:0] c4_words = '0;
    logic [8:0] c4_ram_a;
    logic       c4_ram_o;
    logic       d4_valid;
    logic       d4_ready = 1'b1;
    logic [3:0] d4_data;
    logic       d4_last;
    logic       busy4;
    logic [1:0] state4;

    assign c4_ram_o = ram_bits[c4_ram_a];

    bitram_word_reader #(.DATA_W(4), .MSB_FIRST(1'b1)) dut4 (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(c4_valid), .CMD_READY(c4_ready),
        .CMD_ADDR(c4_addr), .CMD_WORDS(c4_words),
        .RAM_A(c4_ram_a), .RAM_O(c4_ram_o),
        .DOUT_VALID(d4_valid), .DOUT_READY(d4_ready),
        .DOUT_DATA(d4_data), .DOUT_LAST(d4_last),
        .BUSY(busy4), .DBG_STATE(state4)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected words as {last, data}. Bit k of word w comes from
    // address (start + w*8 + k) mod 512.
    logic [8:0] exp_q[$];

    task automatic model_cmd(input int addr, input int words);
        logic [7:0] d;
        for (int w = 0; w < words; w++) begin
            for (int k = 0; k < 8; k++) d[k] = ram_bits[(addr + w * 8 + k) % 512];
            exp_q.push_back({(w == words - 1), d});
        end
    endtask

    function automatic logic [3:0] model4(input int addr);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[3 - k] = ram_bits[(addr + k) % 512];
        return r;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic       stall_seen = 1'b0;
    logic [8:0] stall_word;

    always @(negedge CLK) begin
        if (RST) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                check("stall_valid_held", dout_valid, 1);
                check("stall_word_stable", {dout_last, dout_data}, stall_word);
            end
            stall_seen = 1'b0;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) check("spurious_word_qsize", exp_q.size(), 1);
                else check("word", {dout_last, dout_data}, exp_q.pop_front());
            end else if (dout_valid) begin
                stall_seen = 1'b1;
                stall_word = {dout_last, dout_data};
            end
        end
    end

    // Random DOUT_READY driver, active only when enabled.
    logic rand_ready = 1'b0;
    always @(posedge CLK) begin
        #1;
        if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- driver tasks ----------------
    int acc_cyc;

    // Called and returns at posedge+1.
    task automatic send_cmd(input int addr, input int words, input bit use_model);
        bit ok = 1'b0;
        cmd_addr  = 9'(addr);
        cmd_words = 8'(words);
        cmd_valid = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge CLK);
            if (cmd_ready) ok = 1'b1;
        end
        check("cmd_ready_seen", ok, 1);
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        acc_cyc = cyc;
        if (ok && use_model) model_cmd(addr, words);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !busy) break;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_busy_low", busy, 0);
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (dout_valid) begin
                at_cyc = cyc;
                break;
            end
        end
        check("valid_seen", (at_cyc >= 0), 1);
    endtask

    task automatic run4(input int addr);
        bit ok = 1'b0;
        logic [3:0] e = model4(addr);
        c4_addr  = 9'(addr);
        c4_words = 8'd1;
        c4_valid = 1'b1;
        @(negedge CLK);
        check("w4_cmd_ready", c4_ready, 1);
        @(posedge CLK);
        #1;
        c4_valid = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge CLK);
            if (d4_valid) ok = 1'b1;
        end
        check("w4_valid_seen", ok, 1);
        check("w4_data", d4_data, e);
        check("w4_last", d4_last, 1);
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_ram();
        for (int i = 0; i < 16; i++) ram_bits[i*32 +: 32] = $urandom;
    endtask

    // ---------------- test sequence ----------------
    int t_valid;
    int busy_n;
    int a;

    initial begin
        rand_ram();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset state
        @(negedge CLK);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout_last", dout_last, 0);
        check("rst_dout_data", dout_data, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_ram_a", ram_a, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        @(posedge CLK);
        #1;

        // Test 1: two words from address 0, READY held high
        ram_bits[15:0] = 16'hA53C;
        dout_ready = 1'b1;
        send_cmd(0, 2, 1'b1);
        wait_valid(t_valid);
        check("t1_latency", t_valid - acc_cyc, 8);
        check("t1_word0", dout_data, 8'h3C);
        check("t1_last0", dout_last, 0);
        while (cyc < acc_cyc + 16) @(negedge CLK);
        check("t1_valid1_no_bubble", dout_valid, 1);
        check("t1_word1", dout_data, 8'hA5);
        check("t1_last1", dout_last, 1);
        drain();

        // Test 2: address wrap 511 -> 0
        ram_bits[511] = 1'b1;
        ram_bits[6:0] = 7'd0;
        send_cmd(511, 1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("t2_ram_a_seq", ram_a, (511 + i) % 512);
            @(posedge CLK);
            #1;
        end
        wait_valid(t_valid);
        check("t2_data", dout_data, 8'h01);
        check("t2_last", dout_last, 1);
        drain();

        // Test 3: backpressure
        ram_bits[15:0] = 16'hA53C;
        dout_ready = 1'b0;
        send_cmd(0, 2, 1'b1);
        repeat (30) @(posedge CLK);
        @(negedge CLK);
        check("t3_state_hold", dbg_state, 2);
        check("t3_valid_held", dout_valid, 1);
        check("t3_data_held", dout_data, 8'h3C);
        check("t3_busy", busy, 1);
        @(posedge CLK);
        #1;
        dout_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("t3_next_valid", dout_valid, 1);
        check("t3_next_data", dout_data, 8'hA5);
        check("t3_next_last", dout_last, 1);
        check("t3_state_idle", dbg_state, 0);
        drain();

        // Test 4: zero-word command is a no-op
        send_cmd($urandom_range(0, 511), 0, 1'b0);
        busy_n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (i == 0) check("t4_cmd_ready", cmd_ready, 1);
            check("t4_no_valid", dout_valid, 0);
            if (busy) busy_n++;
        end
        check("t4_busy_at_most_one", (busy_n <= 1), 1);
        @(posedge CLK);
        #1;

        // Test 5: reset mid-command
        a = $urandom_range(0, 511);
        send_cmd(a, 4, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("t5_valid", dout_valid, 0);
        check("t5_cmd_ready", cmd_ready, 1);
        check("t5_ram_a", ram_a, 0);
        check("t5_state", dbg_state, 0);
        @(posedge CLK);
        #1;
        send_cmd(a, 3, 1'b1);
        drain();

        // Test 6: MSB-first, 4-bit words
        ram_bits[3:0] = 4'b0001;
        run4(0);
        check("t6_data_direct", d4_data, 4'h8);
        for (int i = 0; i < 3; i++) run4($urandom_range(0, 511));

        // Randomized back-to-back commands with random backpressure
        rand_ram();
        rand_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            send_cmd($urandom_range(0, 511), $urandom_range(1, 5), 1'b1);
        end
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge CLK);
        rand_ready = 1'b0;
        @(posedge CLK);
        #2;
        dout_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
